// File: rtl/mouse_pkg.sv
// mouse_pkg: shared definitions for the PS/2 mouse receiver.
//   state_t          receiver FSM state encoding (3 bits, 5 legal values)
//   TIMEOUT_DEFAULT  default inter-edge timeout in CLK cycles (0.5 ms at 100 MHz)
//   ERR_PARITY       bit index of the parity-error flag in BYTE_ERROR_CODE
//   ERR_STOP         bit index of the stop-bit-error flag in BYTE_ERROR_CODE
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int TIMEOUT_DEFAULT = 50000;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: brings the PS/2 clock and data lines into the CLK domain.
// Each line goes through a two-flop synchronizer that resets to 1 (the
// idle level of an open-collector PS/2 bus). The clock line also gets a
// falling-edge flag.
//   clk           system clock
//   rst           asynchronous active-high reset
//   ps2_clk_in    raw PS/2 clock line
//   ps2_data_in   raw PS/2 data line
//   ps2_data_sync synchronized data line
//   ps2_clk_fall  high for one cycle when the synchronized clock goes 1 -> 0
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_data_sync,
  output logic ps2_clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  // Shift each line one stage per cycle. clk_prev holds the previous
  // synchronized clock so a falling edge can be seen without extra latency.
  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  // Both lines have the same synchronizer depth, so the data value seen in
  // the edge cycle is the one the device presented before lowering clock.
  assign ps2_data_sync = data_sync_q;
  assign ps2_clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: receive-only PS/2 mouse byte receiver.
// Frames are start(0), D0..D7 (LSB first), odd parity, stop(1), each bit
// sampled on a falling edge of the mouse clock. A finished frame is
// reported with a one-cycle BYTE_READY pulse, even if it had errors.
//   CLK             system clock (100 MHz)
//   RESET           asynchronous active-high reset
//   CLK_MOUSE_IN    PS/2 clock line (asynchronous)
//   DATA_MOUSE_IN   PS/2 data line (asynchronous)
//   READ_ENABLE     low aborts or ignores frames (host is transmitting)
//   BYTE_READ       last received byte
//   BYTE_ERROR_CODE {stop error, parity error} for BYTE_READ
//   BYTE_READY      one-cycle pulse when BYTE_READ/BYTE_ERROR_CODE update
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic data_bit;
  logic clk_fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic          stop_err_q, stop_err_d;
  logic [7:0]    byte_read_q, byte_read_d;
  logic [1:0]    byte_err_q, byte_err_d;
  logic          byte_ready_q, byte_ready_d;

  ps2_sync u_sync (
    .clk           (CLK),
    .rst           (RESET),
    .ps2_clk_in    (CLK_MOUSE_IN),
    .ps2_data_in   (DATA_MOUSE_IN),
    .ps2_data_sync (data_bit),
    .ps2_clk_fall  (clk_fall)
  );

  // Next-state logic. Inside a frame the priority is: READ_ENABLE low
  // aborts, then a falling edge advances the frame (and clears the
  // timeout), then an expired timeout aborts, else the timeout counts up.
  // Aborts leave the reported outputs untouched.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tcnt_d       = tcnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    stop_err_d   = stop_err_q;
    byte_read_d  = byte_read_q;
    byte_err_d   = byte_err_q;
    byte_ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        tcnt_d    = '0;
        if (READ_ENABLE && clk_fall && !data_bit) begin
          state_d = DATA;
        end
      end

      DATA, PARITY, STOP: begin
        if (!READ_ENABLE) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          tcnt_d    = '0;
        end else if (clk_fall) begin
          tcnt_d = '0;
          if (state_q == DATA) begin
            shift_d[bit_cnt_q] = data_bit;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end else if (state_q == PARITY) begin
            // Odd parity: the parity bit must equal the XNOR of the data.
            par_err_d = (data_bit != ~^shift_q);
            state_d   = STOP;
          end else begin
            stop_err_d = (data_bit != 1'b1);
            state_d    = DONE;
          end
        end else if (tcnt_q >= TIMEOUT_MAX) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          tcnt_d    = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      DONE: begin
        byte_read_d             = shift_q;
        byte_err_d[ERR_PARITY]  = par_err_q;
        byte_err_d[ERR_STOP]    = stop_err_q;
        byte_ready_d            = 1'b1;
        state_d                 = IDLE;
        bit_cnt_d               = 3'd0;
        tcnt_d                  = '0;
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
        tcnt_d    = '0;
      end
    endcase
  end

  // All FSM state and outputs are registered here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      tcnt_q       <= '0;
      shift_q      <= 8'h00;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      byte_read_q  <= 8'h00;
      byte_err_q   <= 2'b00;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tcnt_q       <= tcnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      byte_read_q  <= byte_read_d;
      byte_err_q   <= byte_err_d;
      byte_ready_q <= byte_ready_d;
    end
  end

  assign BYTE_READ       = byte_read_q;
  assign BYTE_ERROR_CODE = byte_err_q;
  assign BYTE_READY      = byte_ready_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: directed bench for mouse_receiver. The timeout is
// shrunk to 200 cycles and PS/2 bits are 40 CLK cycles apart so every
// scenario fits in a short run; the timing ratios match the real device.
module tb_mouse_receiver;

  localparam int TB_TIMEOUT = 200;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       read_en;
  logic [7:0] byte_read;
  logic [1:0] err_code;
  logic       ready;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int exp_pulses  = 0;

  mouse_receiver #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK             (clk),
    .RESET           (rst),
    .CLK_MOUSE_IN    (ps2_clk),
    .DATA_MOUSE_IN   (ps2_data),
    .READ_ENABLE     (read_en),
    .BYTE_READ       (byte_read),
    .BYTE_ERROR_CODE (err_code),
    .BYTE_READY      (ready)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Count every cycle BYTE_READY is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (ready === 1'b1) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One PS/2 bit: data set while clock is high, then a low and high phase.
  task automatic applyStimulus(input logic value, input int half);
    ps2_data = value;
    tick(half);
    ps2_clk = 1'b0;
    tick(half);
    ps2_clk = 1'b1;
  endtask

  // Start bit plus the first n data bits of d, then leave the bus idle.
  task automatic send_bits(input logic [7:0] d, input int n, input int half);
    applyStimulus(1'b0, half);
    for (int i = 0; i < n; i++) applyStimulus(d[i], half);
    ps2_data = 1'b1;
  endtask

  // Full frame; around the stop-bit edge the pulse timing is checked:
  // edge driven at cycle k, BYTE_READY must be high only after edge k+4.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int half, input logic exp_pulse,
                            input logic [1:0] exp_code);
    applyStimulus(1'b0, half);
    for (int i = 0; i < 8; i++) applyStimulus(d[i], half);
    applyStimulus(par, half);
    ps2_data = stp;
    tick(half);
    ps2_clk = 1'b0;
    tick(3);
    checkOutput("ready_early", {7'b0, ready}, 8'h00);
    tick(1);
    if (exp_pulse) begin
      checkOutput("ready_pulse", {7'b0, ready}, 8'h01);
      checkOutput("byte_read", byte_read, d);
      checkOutput("error_code", {6'b0, err_code}, {6'b0, exp_code});
      exp_pulses++;
    end else begin
      checkOutput("ready_absent", {7'b0, ready}, 8'h00);
    end
    tick(1);
    checkOutput("ready_width", {7'b0, ready}, 8'h00);
    tick(half - 5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(half);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    read_en  = 1'b1;
    tick(2);
    checkOutput("reset_byte", byte_read, 8'h00);
    checkOutput("reset_code", {6'b0, err_code}, 8'h00);
    checkOutput("reset_ready", {7'b0, ready}, 8'h00);
    rst = 1'b0;
    tick(5);

    // Clean frame, then parity error, then stop error.
    send_frame(8'hFA, 1'b1, 1'b1, HALF, 1'b1, 2'b00);
    send_frame(8'h00, 1'b0, 1'b1, HALF, 1'b1, 2'b01);
    send_frame(8'h08, 1'b0, 1'b0, HALF, 1'b1, 2'b10);

    // Four bits of 0x55 then silence longer than the timeout.
    send_bits(8'h55, 4, HALF);
    tick(300);
    checkOutput("timeout_pulses", 8'(pulses), 8'(exp_pulses));
    checkOutput("timeout_hold_byte", byte_read, 8'h08);
    checkOutput("timeout_hold_code", {6'b0, err_code}, 8'h02);
    send_frame(8'h08, 1'b0, 1'b1, HALF, 1'b1, 2'b00);

    // Whole frame while reception is disabled.
    read_en = 1'b0;
    send_frame(8'hFF, 1'b1, 1'b1, HALF, 1'b0, 2'b00);
    checkOutput("disabled_hold_byte", byte_read, 8'h08);
    read_en = 1'b1;
    tick(5);

    // READ_ENABLE dropped after three data bits.
    send_bits(8'h55, 3, HALF);
    read_en = 1'b0;
    tick(4);
    read_en = 1'b1;
    tick(HALF);
    checkOutput("re_abort_pulses", 8'(pulses), 8'(exp_pulses));
    send_frame(8'hFA, 1'b1, 1'b1, HALF, 1'b1, 2'b00);

    // Asynchronous reset after bit 5 of 0xAA, checked before the next edge.
    send_bits(8'hAA, 6, HALF);
    tick(3);
    rst = 1'b1;
    #1;
    checkOutput("midreset_byte", byte_read, 8'h00);
    checkOutput("midreset_code", {6'b0, err_code}, 8'h00);
    checkOutput("midreset_ready", {7'b0, ready}, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(HALF);
    checkOutput("midreset_pulses", 8'(pulses), 8'(exp_pulses));
    send_frame(8'hF4, 1'b0, 1'b1, HALF, 1'b1, 2'b00);

    // Stray falling edge with data high, then back-to-back frames.
    applyStimulus(1'b1, HALF);
    tick(HALF);
    checkOutput("stray_pulses", 8'(pulses), 8'(exp_pulses));
    send_frame(8'hFA, 1'b1, 1'b1, HALF, 1'b1, 2'b00);
    send_frame(8'h00, 1'b1, 1'b1, HALF, 1'b1, 2'b00);

    // Slow device: 180-cycle edge spacing stays inside the timeout.
    send_frame(8'h55, 1'b1, 1'b1, 90, 1'b1, 2'b00);

    tick(10);
    checkOutput("total_pulses", 8'(pulses), 8'(exp_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
